spraid_stripe_sched: RTL and testbench
======================================

# spraid_stripe_sched

RAID-0 stripe scheduler for the four-channel SPI RAID engine. Accepts one logical block-transfer request at a time, splits it into per-block commands striped across SPI channels 0-3, and issues them to the per-channel SPI engines. Keeps at most one command outstanding per channel, collects completions and errors, and reports a single completion to the Wishbone register front end.

## Interface
Parameters:
- NCH, 4, number of SPI channels; fixed at 4 (channel select is 2 bits).
- LBA_W, 24, logical block address width.
- LEN_W, 8, request length width, in blocks.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  scheduler idle, can accept.
- req_write  in  1  1 = write, 0 = read.
- req_lba  in  LBA_W  first logical block.
- req_len  in  LEN_W  block count; 0 is legal.
- ch_start  out  NCH  one-hot, one-cycle command strobe per channel.
- ch_write  out  1  direction for the strobed command.
- ch_lba  out  LBA_W-2  channel-local block address for the strobed command.
- ch_busy  in  NCH  channel engine busy.
- ch_done  in  NCH  one-cycle completion pulse per channel.
- ch_err  in  NCH  error flag, qualified by ch_done.
- cmp_valid  out  1  one-cycle request-complete pulse.
- cmp_err  out  1  request saw at least one error; valid with cmp_valid.
- cmp_blocks  out  LEN_W  blocks completed without error; valid with cmp_valid.
- busy  out  1  high whenever not IDLE.

## Operation
- The request is accepted on a clock edge where req_valid & req_ready. At that edge, lba, len, and write are latched. The issue index i and done count are cleared, and the sticky error is cleared.
- Block i maps to logical address L = (lba + i) mod 2^LBA_W:
  - Target channel c = L[1:0].
  - Channel-local address = L[LBA_W-1:2].
- State machine:
  - IDLE: req_ready=1. On accept, go to ISSUE.
  - ISSUE: each cycle, if i < len, no error is latched, outstanding[c]=0, and ch_busy[c]=0:
    - Register a start to c.
    - Set outstanding[c] and increment i.
    - Otherwise stall, issuing nothing.
    - Issue is strictly in block order. There is no skipping ahead to free channels.
    - Go to DRAIN when i == len, or when an error has been latched.
  - DRAIN: wait until outstanding == 0, then go to DONE.
  - DONE: assert cmp_valid for one cycle, then go to IDLE.
- Completions are processed in every state:
  - ch_done[k] with outstanding[k]=1 clears outstanding[k].
  - If ch_err[k]=1, the sticky error is set.
  - If ch_err[k]=0, the done count is incremented. Multiple channels may complete in the same cycle; the count adds their total.
  - ch_done[k] with outstanding[k]=0 is ignored entirely.
- An error stops new issues immediately. Outstanding commands still drain, and the request then completes with cmp_err=1.
- len = 0 passes ISSUE → DRAIN → DONE with no ch_start. Completion reports cmp_err=0 and cmp_blocks=0.
- Simultaneous done and issue decision on the same channel: the issue check uses the pre-update outstanding, so the issue waits one cycle.
- cmp_blocks counts good blocks only; it is at most len.

## Timing
- Reset values:
  - req_ready=1, busy=0.
  - ch_start=0, ch_write=0, ch_lba=0.
  - cmp_valid=0, cmp_err=0, cmp_blocks=0.
  - outstanding=0; the state machine is in IDLE.
- Reset mid-request abandons it with no cmp_valid. Channel dones arriving after reset are ignored because outstanding=0.
- All outputs are registered.
- The first ch_start is high in the 2nd cycle after the accept edge. Unstalled issues then come out back-to-back, one per cycle.
- ch_write and ch_lba are valid only while ch_start is nonzero, and hold their value otherwise.
- cmp_valid is high for exactly one cycle, in the cycle after DRAIN observes outstanding==0.
- req_ready is 0 from the accept edge through the cmp_valid cycle. It returns to 1 in the cycle after cmp_valid.
- Minimum request-to-request interval for len=0: 4 cycles.

## Test plan
- lba=0x000005, len=4, write, channels respond 3 cycles after start:
  - ch_start sequence 0b0010, 0b0100, 0b1000, 0b0001 on consecutive cycles.
  - ch_lba = 1, 1, 1, 2.
  - One cmp_valid with cmp_err=0 and cmp_blocks=4.
- lba=0x000000, len=8, channel 0 done delayed 20 cycles:
  - Issues to channels 0-3, then stalls on block 4 (channel 0) until its done.
  - No start is issued to channel 1 before block 4 goes out.
  - Completion reports cmp_blocks=8.
- len=6 with ch_err on the 2nd completion:
  - No further starts after the error.
  - Outstanding commands drain.
  - cmp_err=1 and cmp_blocks = good completions, less than 6.
- lba=0xFFFFFE, len=4:
  - Channel-local addresses 0x3FFFFF, 0x3FFFFF, 0x000000, 0x000000.
  - Channels 2, 3, 0, 1.
- len=0:
  - No ch_start.
  - cmp_valid in the 3rd cycle after accept, with cmp_blocks=0 and cmp_err=0.
- Reset asserted mid-request, and a stray ch_done with no outstanding command:
  - All outputs return to reset values.
  - No cmp_valid.
  - A following len=1 request completes normally with cmp_blocks=1.

Source files
------------

// File: rtl/spraid_stripe_sched.sv
// RAID-0 stripe scheduler: splits one block request into per-channel
// SPI commands, one outstanding per channel, and reports one completion.
module spraid_stripe_sched #(
  parameter int NCH   = 4,
  parameter int LBA_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [LBA_W-1:0] req_lba,
  input  logic [LEN_W-1:0] req_len,
  output logic [NCH-1:0]   ch_start,
  output logic             ch_write,
  output logic [LBA_W-3:0] ch_lba,
  input  logic [NCH-1:0]   ch_busy,
  input  logic [NCH-1:0]   ch_done,
  input  logic [NCH-1:0]   ch_err,
  output logic             cmp_valid,
  output logic             cmp_err,
  output logic [LEN_W-1:0] cmp_blocks,
  output logic             busy
);

  localparam int CW = $clog2(NCH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [LBA_W-1:0] lba_q;
  logic [LEN_W-1:0] len_q;
  logic             wr_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] good_q;
  logic             err_q;
  logic [NCH-1:0]   outst_q;

  logic             accept;
  logic [LBA_W-1:0] blk_addr;
  logic [1:0]       ch_sel;
  logic [NCH-1:0]   sel_oh;
  logic [NCH-1:0]   acc;
  logic [NCH-1:0]   good;
  logic [NCH-1:0]   bad;
  logic [CW-1:0]    good_sum;
  logic             issue;

  assign accept   = req_valid & req_ready;
  assign blk_addr = lba_q + LBA_W'(idx_q);
  assign ch_sel   = blk_addr[1:0];
  assign sel_oh   = NCH'(1) << ch_sel;
  assign acc      = ch_done & outst_q;
  assign good     = acc & ~ch_err;
  assign bad      = acc & ch_err;

  // Number of error-free completions retiring this cycle.
  always_comb begin
    good_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      good_sum = good_sum + CW'(good[k]);
    end
  end

  // Next state and in-order issue decision on pre-update outstanding.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (idx_q == len_q || err_q) begin
          state_n = S_DRAIN;
        end else if (!(|((outst_q | ch_busy) & sel_oh))) begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register plus registered handshake and completion outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_err    <= 1'b0;
      cmp_blocks <= '0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      cmp_valid <= (state_n == S_DONE);
      if (state_n == S_DONE) begin
        cmp_err    <= err_q;
        cmp_blocks <= good_q;
      end
    end
  end

  // Command strobe; direction and address hold between strobes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ch_start <= '0;
      ch_write <= 1'b0;
      ch_lba   <= '0;
    end else begin
      ch_start <= issue ? sel_oh : '0;
      if (issue) begin
        ch_write <= wr_q;
        ch_lba   <= blk_addr[LBA_W-1:2];
      end
    end
  end

  // Request context, issue index, outstanding set and completion tally.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lba_q   <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      good_q  <= '0;
      err_q   <= 1'b0;
      outst_q <= '0;
    end else begin
      outst_q <= (outst_q & ~acc) | (issue ? sel_oh : '0);
      if (accept) begin
        lba_q  <= req_lba;
        len_q  <= req_len;
        wr_q   <= req_write;
        idx_q  <= '0;
        good_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (issue) idx_q <= idx_q + 1'b1;
        if (|bad) err_q <= 1'b1;
        good_q <= good_q + LEN_W'(good_sum);
      end
    end
  end

endmodule

// File: tb/tb_spraid_stripe_sched.sv
// Directed bench for spraid_stripe_sched with a delay-programmable
// channel responder and a start/completion monitor.
module tb_spraid_stripe_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_lba;
  logic [7:0]  req_len;
  logic [3:0]  ch_start;
  logic        ch_write;
  logic [21:0] ch_lba;
  logic [3:0]  ch_busy = '0;
  logic [3:0]  ch_done = '0;
  logic [3:0]  ch_err = '0;
  logic        cmp_valid;
  logic        cmp_err;
  logic [7:0]  cmp_blocks;
  logic        busy;

  spraid_stripe_sched dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_lba   (req_lba),
    .req_len   (req_len),
    .ch_start  (ch_start),
    .ch_write  (ch_write),
    .ch_lba    (ch_lba),
    .ch_busy   (ch_busy),
    .ch_done   (ch_done),
    .ch_err    (ch_err),
    .cmp_valid (cmp_valid),
    .cmp_err   (cmp_err),
    .cmp_blocks(cmp_blocks),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dly[4];
  int err_at = 0;
  int cnt[4] = '{0, 0, 0, 0};
  int ncomp = 0;
  int ngood = 0;
  int err_cyc = 0;
  int ncmp = 0;
  int c_err, c_blk, c_cyc, c_rdy;
  int st_ch[$];
  int st_lba[$];
  int st_cyc[$];
  int st_wr[$];

  // Channel responder and start/completion monitor.
  always @(negedge clk) begin
    ch_done = '0;
    ch_err  = '0;
    for (int k = 0; k < 4; k++) begin
      if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          ch_done[k] = 1'b1;
          ncomp++;
          if (ncomp == err_at) begin
            ch_err[k] = 1'b1;
            err_cyc = cyc;
          end else begin
            ngood++;
          end
        end
      end
      if (ch_start[k]) begin
        cnt[k] = dly[k];
        st_ch.push_back(k);
        st_lba.push_back(int'(ch_lba));
        st_cyc.push_back(cyc);
        st_wr.push_back(int'(ch_write));
      end
    end
    if (cmp_valid) begin
      ncmp++;
      c_err = int'(cmp_err);
      c_blk = int'(cmp_blocks);
      c_cyc = cyc;
      c_rdy = int'(req_ready);
    end
  end

  int n_total = 0;
  int n_bad = 0;
  int acc_cyc, s0, g0, m0;
  int e_ch[8];
  int e_lba[8];
  int e_wr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_req(input logic wr, input logic [23:0] lba,
                           input logic [7:0] len);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_before", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_write = wr;
    req_lba   = lba;
    req_len   = len;
    acc_cyc   = cyc;
    s0 = st_ch.size();
    g0 = ngood;
    m0 = ncmp;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_cmp(input string tag);
    int n;
    n = 0;
    while (ncmp == m0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_cmp_seen"}, 32'(ncmp - m0), 1);
    chk({tag, "_rdy_in_cmp"}, 32'(c_rdy), 0);
    repeat (3) step();
    chk({tag, "_cmp_once"}, 32'(ncmp - m0), 1);
    chk({tag, "_ready_after"}, 32'(req_ready), 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic check_seq(input string tag, input int n);
    chk({tag, "_nstarts"}, 32'(st_ch.size() - s0), 32'(n));
    if (st_ch.size() - s0 >= n) begin
      for (int j = 0; j < n; j++) begin
        chk({tag, "_ch"}, 32'(st_ch[s0+j]), 32'(e_ch[j]));
        chk({tag, "_lba"}, 32'(st_lba[s0+j]), 32'(e_lba[j]));
        chk({tag, "_wr"}, 32'(st_wr[s0+j]), 32'(e_wr));
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_start"}, 32'(ch_start), 0);
    chk({tag, "_write"}, 32'(ch_write), 0);
    chk({tag, "_lba"}, 32'(ch_lba), 0);
    chk({tag, "_cvalid"}, 32'(cmp_valid), 0);
    chk({tag, "_cerr"}, 32'(cmp_err), 0);
    chk({tag, "_cblk"}, 32'(cmp_blocks), 0);
  endtask

  initial begin
    int m1;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_lba = '0;
    req_len = '0;
    dly = '{3, 3, 3, 3};
    repeat (3) step();
    chk_reset_outs("rst0");
    rst = 1'b0;
    step();
    chk_reset_outs("idle0");

    // lba 5, len 4, write: channels 1,2,3,0 back-to-back
    e_ch  = '{1, 2, 3, 0, 0, 0, 0, 0};
    e_lba = '{1, 1, 1, 2, 0, 0, 0, 0};
    e_wr  = 1;
    issue_req(1'b1, 24'h000005, 8'd4);
    wait_cmp("t1");
    check_seq("t1", 4);
    if (st_ch.size() - s0 >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("t1_cyc", 32'(st_cyc[s0+j]), 32'(acc_cyc + 2 + j));
      end
    end
    chk("t1_err", 32'(c_err), 0);
    chk("t1_blk", 32'(c_blk), 4);

    // len 8 with slow channel 0: strict in-order stall on block 4
    dly   = '{20, 3, 3, 3};
    e_ch  = '{0, 1, 2, 3, 0, 1, 2, 3};
    e_lba = '{0, 0, 0, 0, 1, 1, 1, 1};
    e_wr  = 0;
    issue_req(1'b0, 24'h000000, 8'd8);
    wait_cmp("t2");
    check_seq("t2", 8);
    if (st_ch.size() - s0 >= 8) begin
      chk("t2_stall", 32'(st_cyc[s0+4] - st_cyc[s0] >= 21), 1);
    end
    chk("t2_err", 32'(c_err), 0);
    chk("t2_blk", 32'(c_blk), 8);

    // len 6 with error on the second completion
    dly = '{3, 3, 3, 3};
    err_at = ncomp + 2;
    issue_req(1'b1, 24'h000000, 8'd6);
    wait_cmp("t3");
    err_at = 0;
    chk("t3_fewer", 32'(st_ch.size() - s0 < 6), 1);
    if (st_ch.size() > s0) begin
      chk("t3_stop", 32'(st_cyc[st_ch.size()-1] <= err_cyc + 1), 1);
    end
    chk("t3_err", 32'(c_err), 1);
    chk("t3_blk", 32'(c_blk), 32'(ngood - g0));
    chk("t3_blk_lt", 32'(c_blk < 6), 1);

    // address wrap at top of LBA space
    e_ch  = '{2, 3, 0, 1, 0, 0, 0, 0};
    e_lba = '{32'h3FFFFF, 32'h3FFFFF, 0, 0, 0, 0, 0, 0};
    e_wr  = 0;
    issue_req(1'b0, 24'hFFFFFE, 8'd4);
    wait_cmp("t4");
    check_seq("t4", 4);
    chk("t4_err", 32'(c_err), 0);
    chk("t4_blk", 32'(c_blk), 4);

    // zero-length request
    issue_req(1'b1, 24'h000123, 8'd0);
    wait_cmp("t5");
    chk("t5_nstarts", 32'(st_ch.size() - s0), 0);
    chk("t5_cmp_cyc", 32'(c_cyc), 32'(acc_cyc + 3));
    chk("t5_err", 32'(c_err), 0);
    chk("t5_blk", 32'(c_blk), 0);

    // reset mid-request, stray dones afterwards
    dly = '{20, 3, 3, 3};
    issue_req(1'b1, 24'h000040, 8'd8);
    repeat (6) step();
    chk("t6_busy_pre", 32'(busy), 1);
    m1 = ncmp;
    rst = 1'b1;
    step();
    chk_reset_outs("t6_rst");
    step();
    rst = 1'b0;
    step();
    chk_reset_outs("t6_post");
    repeat (30) step();
    chk("t6_no_cmp", 32'(ncmp - m1), 0);
    chk("t6_start_quiet", 32'(ch_start), 0);
    chk("t6_ready", 32'(req_ready), 1);
    dly = '{3, 3, 3, 3};
    e_ch  = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_lba = '{4, 0, 0, 0, 0, 0, 0, 0};
    e_wr  = 0;
    issue_req(1'b0, 24'h000010, 8'd1);
    wait_cmp("t6b");
    check_seq("t6b", 1);
    chk("t6b_err", 32'(c_err), 0);
    chk("t6b_blk", 32'(c_blk), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
